// File: rtl/rx_cmd_decoder_pkg.sv
// Shared constants for the host command link. The game core uses them too.
//   SyncByteDef   : default frame start marker
//   Cmd*          : command codes carried in the CMD byte
//   lane_e        : arrow lane encoding carried in ARG[1:0] of a hit command
//   state_e       : frame decoder states (sync, cmd, arg, chk)
//   timer_width() : inter-byte timer width for a given timeout, never below 1 bit
package rx_cmd_decoder_pkg;

  localparam logic [7:0] SyncByteDef = 8'hA5;

  localparam logic [7:0] CmdPause    = 8'h01;
  localparam logic [7:0] CmdNextSong = 8'h02;
  localparam logic [7:0] CmdHit      = 8'h03;
  localparam logic [7:0] CmdScoreClr = 8'h04;

  typedef enum logic [1:0] {
    LaneL = 2'd0,
    LaneD = 2'd1,
    LaneU = 2'd2,
    LaneR = 2'd3
  } lane_e;

  typedef enum logic [1:0] {
    StSync = 2'd0,
    StCmd  = 2'd1,
    StArg  = 2'd2,
    StChk  = 2'd3
  } state_e;

  function automatic int unsigned timer_width(input int unsigned cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/rx_cmd_decoder_if.sv
// Byte-in / command-out bundle between the UART receiver side and the decoder.
//   rx_data, rx_valid : received byte and its one-cycle qualifier
//   pause             : pause level for the game core
//   next_song         : one-cycle next-song request
//   score_clr         : one-cycle score clear
//   hit_valid         : one-cycle host-injected hit, hit_lane valid alongside
//   frame_err         : one-cycle pulse per rejected or timed-out frame
//   err_cnt           : saturating count of rejected frames
// master drives bytes and observes commands; slave is the decoder.
interface rx_cmd_decoder_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pause;
  logic       next_song;
  logic       score_clr;
  logic       hit_valid;
  logic [1:0] hit_lane;
  logic       frame_err;
  logic [7:0] err_cnt;

  modport master (
    output rx_data, rx_valid,
    input  pause, next_song, score_clr, hit_valid, hit_lane, frame_err, err_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output pause, next_song, score_clr, hit_valid, hit_lane, frame_err, err_cnt
  );

endinterface

// File: rtl/rx_cmd_decoder.sv
// Host command frame decoder. Frames are SYNC, CMD, ARG, CHK with CHK = CMD ^ ARG.
// Valid frames drive pause / next_song / score_clr / hit outputs one cycle after the
// CHK byte; bad checksums, unknown commands and inter-byte timeouts pulse frame_err
// and bump a saturating error counter.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : rx_cmd_decoder_if slave modport (bytes in, commands out)
module rx_cmd_decoder
  import rx_cmd_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SyncByteDef,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic              clk,
  input logic              rst,
  rx_cmd_decoder_if.slave  bus
);

  localparam int unsigned       TimerW   = timer_width(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [TimerW-1:0] timer_q;
  logic [7:0]        cmd_q;
  logic [7:0]        arg_q;
  logic              pause_q;
  logic              next_song_q;
  logic              score_clr_q;
  logic              hit_valid_q;
  logic [1:0]        hit_lane_q;
  logic              frame_err_q;
  logic [7:0]        err_cnt_q;

  logic       chk_ok;
  logic       cmd_known;
  logic [7:0] err_cnt_inc;

  always_comb begin
    chk_ok      = (bus.rx_data == (cmd_q ^ arg_q));
    cmd_known   = (cmd_q == CmdPause) || (cmd_q == CmdNextSong) ||
                  (cmd_q == CmdHit)   || (cmd_q == CmdScoreClr);
    err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StSync;
      timer_q     <= '0;
      cmd_q       <= '0;
      arg_q       <= '0;
      pause_q     <= 1'b0;
      next_song_q <= 1'b0;
      score_clr_q <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_lane_q  <= 2'd0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      next_song_q <= 1'b0;
      score_clr_q <= 1'b0;
      hit_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      // A byte arriving in the expiry cycle takes priority over the timeout.
      if (bus.rx_valid) begin
        timer_q <= '0;
        unique case (state_q)
          StSync: begin
            if (bus.rx_data == SYNC_BYTE) state_q <= StCmd;
          end
          StCmd: begin
            cmd_q   <= bus.rx_data;
            state_q <= StArg;
          end
          StArg: begin
            arg_q   <= bus.rx_data;
            state_q <= StChk;
          end
          StChk: begin
            state_q <= StSync;
            if (chk_ok && cmd_known) begin
              case (cmd_q)
                CmdPause:    pause_q     <= arg_q[0];
                CmdNextSong: next_song_q <= 1'b1;
                CmdHit: begin
                  hit_valid_q <= 1'b1;
                  hit_lane_q  <= arg_q[1:0];
                end
                CmdScoreClr: score_clr_q <= 1'b1;
                default: ;
              endcase
            end else begin
              frame_err_q <= 1'b1;
              err_cnt_q   <= err_cnt_inc;
            end
          end
          default: state_q <= StSync;
        endcase
      end else if (state_q != StSync) begin
        if (timer_q == TimerMax) begin
          state_q     <= StSync;
          timer_q     <= '0;
          frame_err_q <= 1'b1;
          err_cnt_q   <= err_cnt_inc;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  assign bus.pause     = pause_q;
  assign bus.next_song = next_song_q;
  assign bus.score_clr = score_clr_q;
  assign bus.hit_valid = hit_valid_q;
  assign bus.hit_lane  = hit_lane_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Randomized bench for rx_cmd_decoder against a byte-level frame model.
module tb_rx_cmd_decoder;

  localparam int unsigned Timeout = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rx_cmd_decoder_if bus ();

  rx_cmd_decoder #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (Timeout)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: collects frame bytes after a sync byte, counts idle cycles.
  logic [7:0] m_frame[$];
  bit         m_in_frame;
  int         m_idle;
  bit         m_pause;
  int         m_err;
  bit         e_next;
  bit         e_clr;
  bit         e_hit;
  bit [1:0]   e_lane;
  bit         e_ferr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_in_frame = 0;
    m_idle     = 0;
    m_pause    = 0;
    m_err      = 0;
    e_next = 0; e_clr = 0; e_hit = 0; e_lane = 0; e_ferr = 0;
  endtask

  task automatic model_reject();
    e_ferr = 1;
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    logic [7:0] cmd;
    logic [7:0] arg;
    e_next = 0; e_clr = 0; e_hit = 0; e_ferr = 0;
    if (v) begin
      m_idle = 0;
      if (!m_in_frame) begin
        if (d == 8'hA5) begin
          m_in_frame = 1;
          m_frame.delete();
        end
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == 3) begin
          m_in_frame = 0;
          cmd = m_frame[0];
          arg = m_frame[1];
          if (m_frame[2] != (cmd ^ arg)) model_reject();
          else if (cmd == 8'h01) m_pause = arg[0];
          else if (cmd == 8'h02) e_next = 1;
          else if (cmd == 8'h03) begin e_hit = 1; e_lane = arg[1:0]; end
          else if (cmd == 8'h04) e_clr = 1;
          else model_reject();
        end
      end
    end else if (m_in_frame) begin
      m_idle++;
      if (m_idle == Timeout) begin
        m_in_frame = 0;
        m_idle     = 0;
        model_reject();
      end
    end
  endtask

  task automatic check_outputs();
    check_val("pause", bus.pause, m_pause);
    check_val("next_song", bus.next_song, e_next);
    check_val("score_clr", bus.score_clr, e_clr);
    check_val("hit_valid", bus.hit_valid, e_hit);
    check_val("frame_err", bus.frame_err, e_ferr);
    check_val("err_cnt", bus.err_cnt, m_err);
    if (e_hit) check_val("hit_lane", bus.hit_lane, e_lane);
  endtask

  // Called at posedge+1; returns at the next posedge+1 after checking.
  task automatic step(input bit v, input logic [7:0] d);
    bus.rx_valid = v;
    bus.rx_data  = v ? d : 8'h00;
    @(posedge clk);
    #1;
    model_step(v, d);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send(8'hA5); send(c); send(a); send(k);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    #12;
    check_outputs();
    check_val("rst_hit_lane", bus.hit_lane, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed frames
    send_frame(8'h01, 8'h01, 8'h00);
    check_val("pause_set", bus.pause, 1'b1);
    send_frame(8'h01, 8'h00, 8'h01);
    check_val("pause_clr", bus.pause, 1'b0);
    send_frame(8'h03, 8'h02, 8'h01);
    check_val("hit_lane2", bus.hit_lane, 2'd2);
    idle(1);
    send_frame(8'h02, 8'h00, 8'h02);
    send_frame(8'h04, 8'h00, 8'h05);
    check_val("bad_chk_cnt", bus.err_cnt, 8'd1);
    send_frame(8'h07, 8'h00, 8'h07);
    check_val("unknown_cnt", bus.err_cnt, 8'd2);
    send(8'h00); send(8'hFF);
    send_frame(8'h04, 8'h00, 8'h04);
    check_val("junk_cnt", bus.err_cnt, 8'd2);
    // Timeout exactly at the limit, then a byte exactly at expiry
    send(8'hA5); send(8'h01);
    idle(Timeout);
    check_val("timeout_err", bus.err_cnt, 8'd3);
    send_frame(8'h02, 8'h00, 8'h02);
    send(8'hA5); idle(Timeout - 1); send(8'h03); idle(Timeout - 1); send(8'h01);
    idle(Timeout - 1); send(8'h02);
    // Sync byte used as ordinary data inside a frame
    send_frame(8'h03, 8'hA5, 8'hA6);
    // Back-to-back frames
    send_frame(8'h04, 8'h11, 8'h15);
    send_frame(8'h02, 8'h33, 8'h31);

    // Randomized frames with random gaps, junk and corruption
    for (int i = 0; i < 250; i++) begin
      logic [7:0] c;
      logic [7:0] a;
      logic [7:0] k;
      if ($urandom_range(0, 4) == 0) send(8'($urandom));
      c = 8'($urandom_range(0, 6));
      a = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ a);
      send(8'hA5);
      for (int j = 0; j < 3; j++) begin
        int gap;
        gap = ($urandom_range(0, 14) == 0) ? int'($urandom_range(Timeout - 2, Timeout + 1))
                                           : int'($urandom_range(0, 2));
        idle(gap);
        send((j == 0) ? c : (j == 1) ? a : k);
      end
      idle($urandom_range(0, 2));
    end

    // Saturate the error counter
    for (int i = 0; i < 300; i++) send_frame(8'h04, 8'($urandom), 8'h00 ^ 8'h5A);
    check_val("err_sat", bus.err_cnt, 8'hFF);

    // Asynchronous reset in the middle of a frame
    send_frame(8'h01, 8'h01, 8'h00);
    send(8'hA5); send(8'h01);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("async_hit_lane", bus.hit_lane, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send(8'h04); send(8'h00); send(8'h04);
    send_frame(8'h04, 8'h00, 8'h04);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_cmd_decoder.md
RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, max idle cycles between bytes inside a frame.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  received byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 pause  output  1  registered pause level for the game core.
REQ-008 next_song  output  1  one-cycle pulse requesting next song.
REQ-009 score_clr  output  1  one-cycle pulse clearing score.
REQ-010 hit_valid  output  1  one-cycle pulse, host-injected arrow hit.
REQ-011 hit_lane  output  2  lane of hit (0=L,1=D,2=U,3=R), valid with hit_valid.
REQ-012 frame_err  output  1  one-cycle pulse on any rejected frame.
REQ-013 err_cnt  output  8  saturating count of rejected frames.

Function
REQ-014 Frame format: SYNC_BYTE, CMD, ARG, CHK; CHK = CMD XOR ARG.
REQ-015 FSM states S_SYNC, S_CMD, S_ARG, S_CHK; advance only on rx_valid.
REQ-016 S_SYNC: byte == SYNC_BYTE -> S_CMD; any other byte discarded silently, no error.
REQ-017 S_CMD: latch CMD -> S_ARG; S_ARG: latch ARG -> S_CHK; S_CHK: evaluate, -> S_SYNC.
REQ-018 Valid CHK with CMD 8'h01: pause <= ARG[0]; held until next PAUSE command or reset.
REQ-019 Valid CHK with CMD 8'h02: next_song pulse; ARG ignored.
REQ-020 Valid CHK with CMD 8'h03: hit_valid pulse, hit_lane = ARG[1:0]; ARG[7:2] ignored.
REQ-021 Valid CHK with CMD 8'h04: score_clr pulse; ARG ignored.
REQ-022 Latency: command output asserted exactly one cycle after the clk edge sampling the CHK byte.
REQ-023 CHK mismatch or unknown CMD: no command output; frame_err pulse, same timing as REQ-022.
REQ-024 Inter-byte timer: cleared on every rx_valid; counts only in S_CMD/S_ARG/S_CHK; held at 0 in S_SYNC.
REQ-025 Timer reaching TIMEOUT_CYCLES-1 without rx_valid: -> S_SYNC, frame_err pulse, partial frame dropped.
REQ-026 rx_valid in the same cycle as timer expiry: byte wins, no timeout.
REQ-027 SYNC_BYTE value received in S_CMD/S_ARG/S_CHK is treated as ordinary data, not resync.
REQ-028 err_cnt increments by 1 per frame_err pulse; saturates at 8'hFF, no wrap.
REQ-029 At most one pulse output high per cycle; pulses never exceed one cycle.
REQ-030 Back-to-back frames with rx_valid on consecutive cycles accepted without loss.

Reset
REQ-031 rst low: FSM -> S_SYNC, timer 0, latched CMD/ARG 0, pause 0, all pulses 0, hit_lane 0, err_cnt 0, immediately and asynchronously.
REQ-032 rst deassertion mid-frame: partial frame lost; decoding resumes awaiting SYNC_BYTE.

Structure
REQ-033 Command codes (8'h01-8'h04), SYNC_BYTE default, and lane encoding reside in shared ddrdefs constants, also used by the game core.
REQ-034 Single module; no sub-modules; timer width = clog2(TIMEOUT_CYCLES).

Verification
REQ-035 Bytes A5,01,01,00 -> pause=1 one cycle after CHK; then A5,01,00,01 -> pause=0.
REQ-036 Bytes A5,03,02,01 -> hit_valid one cycle, hit_lane=2; A5,02,00,02 -> next_song pulse only.
REQ-037 Bytes A5,04,00,05 (bad CHK) -> frame_err pulse, err_cnt=1, no score_clr; A5,07,00,07 -> frame_err, err_cnt=2.
REQ-038 Bytes 00,FF,A5,04,00,04 -> leading junk ignored, score_clr pulse, err_cnt unchanged.
REQ-039 TIMEOUT_CYCLES=16: A5,01 then 16 idle cycles -> frame_err, FSM in S_SYNC; following A5,02,00,02 -> next_song.
REQ-040 300 bad-CHK frames -> err_cnt=FF; rst low mid-frame -> all outputs 0 within same cycle.
